// File: rtl/fadd_issue_ctrl_pkg.sv
// fadd_issue_ctrl_pkg
// Shared types and defaults for the float-adder issue controller.
//   token_t : in-flight marker travelling alongside the adder pipeline
//   rsp_t   : buffered result record held in the response FIFO
package fadd_issue_ctrl_pkg;

    // Register stages between the operand register and a valid fa_s sample.
    localparam int FADD_LATENCY = 29;
    localparam int RSP_DEPTH    = 8;
    localparam int PKG_TAG_W    = 4;

    typedef struct packed {
        logic                 valid;
        logic                 src;
        logic [PKG_TAG_W-1:0] tag;
    } token_t;

    typedef struct packed {
        logic [31:0]          data;
        logic                 src;
        logic [PKG_TAG_W-1:0] tag;
    } rsp_t;

endpackage

// File: rtl/fadd_rsp_fifo.sv
// fadd_rsp_fifo
// First-word-fall-through response buffer, DEPTH entries of rsp_t.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   wr_en, wr_data   push (must never occur while full)
//   rd_en            pop request, ignored while empty
//   rd_data          current head entry (valid when !empty)
//   full, empty      occupancy flags
//   count            occupancy, 0..DEPTH
module fadd_rsp_fifo
    import fadd_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = RSP_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  rsp_t        wr_data,
    input  logic        rd_en,
    output rsp_t        rd_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    rsp_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_rd;

    assign do_rd   = rd_en & ~empty;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; entries are only visible once written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));

endmodule

// File: rtl/fadd_issue_ctrl.sv
// fadd_issue_ctrl
// Round-robin issue controller for a fixed-latency float adder that has no
// handshake of its own. A token pipe mirrors the adder pipeline so each sum
// is captured with its requester/tag; a credit count covering in-flight plus
// buffered results keeps the response FIFO from ever overflowing.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid/ready/a/b/tag   requester N issue handshake (N = 0, 1)
//   fa_a, fa_b                 registered adder operands (0 when idle)
//   fa_s                       adder result, LATENCY edges after fa_a/fa_b
//   rsp_valid/ready            response handshake
//   rsp_data, rsp_src, rsp_tag response payload
//   busy                       any operation in flight or buffered
module fadd_issue_ctrl
    import fadd_issue_ctrl_pkg::*;
#(
    parameter int LATENCY = FADD_LATENCY,
    parameter int DEPTH   = RSP_DEPTH,
    parameter int TAG_W   = PKG_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      fa_a,
    output logic [31:0]      fa_b,
    input  logic [31:0]      fa_s,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_src,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Token and response records come from the package at a fixed tag width.
    if (TAG_W != PKG_TAG_W) begin : g_tag_w_check
        $error("fadd_issue_ctrl: TAG_W must equal PKG_TAG_W");
    end

    logic          en;
    logic [CW-1:0] cnt;
    logic          rr_ptr;
    token_t        pipe [LATENCY];

    logic          can_issue;
    logic          grant0;
    logic          grant1;
    logic          issue;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    rsp_t          fifo_wr;
    rsp_t          fifo_rd;

    // en holds ready low until the first edge after reset release, so ready
    // never asserts while reset is active even if requesters are valid.
    assign can_issue  = en && (cnt < CW'(DEPTH));
    assign grant0     = req0_valid && (!req1_valid || !rr_ptr);
    assign grant1     = req1_valid && (!req0_valid ||  rr_ptr);
    assign req0_ready = can_issue & grant0;
    assign req1_ready = can_issue & grant1;
    assign issue      = req0_ready | req1_ready;
    assign pop        = rsp_valid & rsp_ready;
    assign busy       = (cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en     <= 1'b0;
            cnt    <= '0;
            rr_ptr <= 1'b0;
            fa_a   <= '0;
            fa_b   <= '0;
            for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else begin
            en <= 1'b1;
            case ({issue, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (issue) begin
                rr_ptr  <= req0_ready;
                fa_a    <= req0_ready ? req0_a : req1_a;
                fa_b    <= req0_ready ? req0_b : req1_b;
                pipe[0] <= token_t'{valid: 1'b1,
                                    src:   req1_ready,
                                    tag:   req0_ready ? req0_tag : req1_tag};
            end else begin
                fa_a    <= '0;
                fa_b    <= '0;
                pipe[0] <= '0;
            end
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    // The last token lines up with the sum currently on fa_s.
    assign fifo_wr = rsp_t'{data: fa_s,
                            src:  pipe[LATENCY-1].src,
                            tag:  pipe[LATENCY-1].tag};

    fadd_rsp_fifo #(
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (pipe[LATENCY-1].valid),
        .wr_data (fifo_wr),
        .rd_en   (rsp_ready),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_data  = fifo_rd.data;
    assign rsp_src   = fifo_rd.src;
    assign rsp_tag   = fifo_rd.tag;

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
                                     (fifo_count <= cnt) && !(fifo_full && pipe[LATENCY-1].valid));

endmodule

// File: tb/tb_fadd_issue_ctrl.sv
module tb_fadd_issue_ctrl;

    localparam int LAT   = 29;
    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] data;
        logic        src;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_tag = '0, req1_tag = '0;
    logic [31:0] fa_a, fa_b, fa_s;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_src;
    logic [3:0]  rsp_tag;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    int mcnt = 0;
    int acc = 0;
    int pops = 0;
    int hs_edge = 0;
    int pop_cyc = 0;
    int n0_left = 0, n1_left = 0;
    logic last_r0 = 1'b0, last_r1 = 1'b0;
    exp_t last_rsp;
    exp_t sb [$];
    int   glog [$];
    int   acc_edges [$];
    int   a0, p0;

    fadd_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .fa_a(fa_a), .fa_b(fa_b), .fa_s(fa_s),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_src(rsp_src), .rsp_tag(rsp_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    // Adder stand-in: 1.0 + 2.0 gives 3.0, anything else a distinct pattern.
    function automatic logic [31:0] fmodel(logic [31:0] a, logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b + 32'h0101_0101;
    endfunction

    // Sum appears on fa_s for the edge LAT edges after the operand update.
    logic [31:0] apipe [LAT-1];
    initial for (int i = 0; i < LAT-1; i++) apipe[i] = '0;
    always @(posedge clk) begin
        apipe[0] <= fmodel(fa_a, fa_b);
        for (int i = 1; i < LAT-1; i++) apipe[i] <= apipe[i-1];
    end
    assign fa_s = apipe[LAT-2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: observe at negedge, then advance and re-drive after the edge.
    task automatic cyc();
        logic hs0, hs1, pop;
        exp_t e;
        @(negedge clk);
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
        pop = rsp_valid && rsp_ready;
        last_r0 = req0_ready;
        last_r1 = req1_ready;
        chk("busy_vs_credits", 32'(busy), 32'(mcnt != 0));
        chk("ready_onehot", 32'(req0_ready && req1_ready), 0);
        chk("ready_needs_credit", 32'((req0_ready || req1_ready) && mcnt >= DEPTH), 0);
        if (pop) begin
            chk("rsp_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_src", 32'(rsp_src), 32'(e.src));
                chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
            end
            last_rsp = '{rsp_data, rsp_src, rsp_tag};
            pops++;
            pop_cyc = ncyc;
        end
        if (hs0) begin
            sb.push_back('{fmodel(req0_a, req0_b), 1'b0, req0_tag});
            glog.push_back(0);
        end
        if (hs1) begin
            sb.push_back('{fmodel(req1_a, req1_b), 1'b1, req1_tag});
            glog.push_back(1);
        end
        if (hs0 || hs1) begin
            acc++;
            hs_edge = ncyc + 1;
            acc_edges.push_back(ncyc + 1);
        end
        mcnt = mcnt + int'(hs0) + int'(hs1) - int'(pop);
        @(posedge clk);
        #1;
        if (hs0) begin
            n0_left--;
            req0_valid = (n0_left != 0);
            req0_tag++;
            req0_a = $urandom;
            req0_b = $urandom;
        end
        if (hs1) begin
            n1_left--;
            req1_valid = (n1_left != 0);
            req1_tag++;
            req1_a = $urandom;
            req1_b = $urandom;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n0_left = 0;
        n1_left = 0;
        sb.delete();
        mcnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 150 && (sb.size() != 0 || mcnt != 0); i++) cyc();
        chk("drain_sb_empty", 32'(sb.size()), 0);
        chk("drain_not_busy", 32'(busy), 0);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_fa_a"}, fa_a, 0);
        chk({tag, "_fa_b"}, fa_b, 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_req0_ready"}, 32'(req0_ready), 0);
        chk({tag, "_req1_ready"}, 32'(req1_ready), 0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single op
        req0_a = 32'h3F80_0000;
        req0_b = 32'h4000_0000;
        req0_tag = 4'd3;
        n0_left = 1;
        req0_valid = 1'b1;
        rsp_ready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 80 && pops == p0; i++) cyc();
        chk("single_one_rsp", 32'(pops - p0), 1);
        chk("single_latency", 32'(pop_cyc - hs_edge), LAT);
        chk("single_data", last_rsp.data, 32'h4040_0000);
        chk("single_src", 32'(last_rsp.src), 0);
        chk("single_tag", 32'(last_rsp.tag), 3);
        chk("single_busy_after_pop", 32'(busy), 0);

        // Contention
        do_reset();
        glog.delete();
        req0_tag = 4'h5;
        req1_tag = 4'hA;
        n0_left = 2;
        n1_left = 2;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 20 && glog.size() < 4; i++) cyc();
        chk("rr_grants", 32'(glog.size()), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("rr_order", 32'(glog[i]), 32'(i % 2));
        drain();

        // Backpressure
        do_reset();
        rsp_ready = 1'b0;
        n0_left = 100;
        req0_valid = 1'b1;
        a0 = acc;
        repeat (60) cyc();
        chk("bp_accepts", 32'(acc - a0), 8);
        chk("bp_ready_low", 32'(last_r0), 0);
        chk("bp_fifo_holding", 32'(rsp_valid), 1);
        p0 = pops;
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        chk("bp_one_pop", 32'(pops - p0), 1);
        chk("bp_no_same_cycle_accept", 32'(last_r0), 0);
        cyc();
        chk("bp_next_cycle_ready", 32'(last_r0), 1);
        chk("bp_one_more_accept", 32'(acc - a0), 9);
        repeat (5) cyc();
        chk("bp_no_extra_accept", 32'(acc - a0), 9);
        n0_left = 0;
        req0_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // Back-to-back
        do_reset();
        rsp_ready = 1'b1;
        acc_edges.delete();
        p0 = pops;
        n1_left = 20;
        req1_valid = 1'b1;
        for (int i = 0; i < 200 && acc_edges.size() < 20; i++) cyc();
        chk("b2b_accepts", 32'(acc_edges.size()), 20);
        if (acc_edges.size() >= 9) begin
            chk("b2b_first8_consecutive", 32'(acc_edges[7] - acc_edges[0]), 7);
            chk("b2b_stall_until_return", 32'(acc_edges[8] - acc_edges[0]), LAT + 2);
        end
        drain();
        chk("b2b_pops", 32'(pops - p0), 20);

        // Reset mid-flight
        do_reset();
        rsp_ready = 1'b1;
        a0 = acc;
        n0_left = 5;
        req0_valid = 1'b1;
        for (int i = 0; i < 20 && acc - a0 < 5; i++) cyc();
        chk("mid_five_in_flight", 32'(acc - a0), 5);
        repeat (4) cyc();
        req1_a = 32'h1111_2222;
        req1_b = 32'h0303_0404;
        req1_tag = 4'h9;
        n1_left = 1;
        req1_valid = 1'b1;
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("mid_reset");
        sb.delete();
        mcnt = 0;
        @(posedge clk);
        #1;
        chk_reset_outputs("mid_reset_held");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        p0 = pops;
        repeat (70) cyc();
        chk("mid_only_new_rsp", 32'(pops - p0), 1);
        chk("mid_new_src", 32'(last_rsp.src), 1);
        chk("mid_new_tag", 32'(last_rsp.tag), 9);
        chk("mid_new_data", last_rsp.data, fmodel(32'h1111_2222, 32'h0303_0404));

        // Idle
        for (int i = 0; i < 40; i++) begin
            cyc();
            chk("idle_fa_a", fa_a, 0);
            chk("idle_fa_b", fa_b, 0);
            chk("idle_rsp_valid", 32'(rsp_valid), 0);
            chk("idle_busy", 32'(busy), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fadd_issue_ctrl.md
Name: fadd_issue_ctrl

Overview:
- Issue controller and arbiter for the fixed-latency pipelined single-precision float adder.
- The adder has no valid, stall or tag signals. It accepts one operand pair per clock and presents the sum a fixed LATENCY cycles later.
- This block arbitrates two requesters onto the adder and tracks in-flight operations with a valid/tag shift pipe. It buffers results in a response FIFO and uses credits so that no result is ever dropped under backpressure.

Parameters:
- LATENCY, 29: clock edges from the operand register update to a valid result on fa_s.
- DEPTH, 8: response FIFO entries; also the total credit count (in-flight plus buffered).
- TAG_W, 4: width of the requester-supplied tag.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  32  requester 0 operand a (IEEE-754 single).
- req0_b  in  32  requester 0 operand b.
- req0_tag  in  TAG_W  requester 0 tag.
- req1_valid, req1_ready, req1_a, req1_b, req1_tag: same as requester 0, for requester 1.
- fa_a  out  32  adder operand a (registered).
- fa_b  out  32  adder operand b (registered).
- fa_s  in  32  adder result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  32  sum.
- rsp_src  out  1  originating requester.
- rsp_tag  out  TAG_W  originating tag.
- busy  out  1  any operation in flight or buffered.

Behaviour:
- Reset (async assert, sync release):
  - fa_a = fa_b = 0.
  - rsp_valid = 0, busy = 0, req0_ready = req1_ready = 0.
  - Token pipe cleared, FIFO emptied, credit count = 0, round-robin pointer = requester 0.
  - Reset mid-operation discards all in-flight and buffered operations; no response is ever produced for them.
- Credits:
  - cnt = in-flight tokens + FIFO occupancy, held in a register.
  - can_issue = (cnt < DEPTH), evaluated from registered state only.
  - No combinational path from rsp_ready to reqN_ready.
- Arbitration (combinational grant, round-robin):
  - One requester valid: it is granted.
  - Both valid: the requester selected by the pointer is granted.
  - reqN_ready = can_issue & grantN; at most one ready per cycle.
  - On a handshake the pointer moves to the other requester; otherwise it holds.
- Issue, at an edge with a handshake (edge T):
  - fa_a/fa_b load the granted operands.
  - A token {valid=1, src, tag} enters stage 0 of the LATENCY-deep token pipe.
  - cnt increments.
- No issue: fa_a/fa_b load 0 and a bubble token (valid=0) enters the pipe.
- Token pipe:
  - Shifts every cycle, never stalls.
  - The token reaches the pipe end at edge T+LATENCY-1.
  - At edge T+LATENCY, {fa_s, src, tag} is written into the FIFO.
  - Credits guarantee the FIFO is never full at a write; a full-at-write condition is an assertion failure.
- Response:
  - rsp_* shows the FIFO head, first-word-fall-through.
  - rsp_valid = FIFO not empty.
  - Pop on rsp_valid & rsp_ready; the pop decrements cnt.
- Simultaneous issue and pop in one cycle: cnt unchanged. The freed credit is visible to can_issue only from the next cycle.
- Simultaneous FIFO write (pipe exit) and pop: both occur; occupancy unchanged.
- Minimum accept-to-rsp_valid latency: LATENCY+1 edges, i.e. rsp_valid rises the cycle after the write edge.
- busy = (cnt != 0).
- Ordering: responses appear in issue order across both requesters.
- FIFO pointers are log2(DEPTH) bits wide and wrap modulo DEPTH; the count is log2(DEPTH)+1 bits.

Decomposition:
- Shared package: the token record type {valid, src, tag}.
- Shared package: the response record type {data, src, tag}.
- Shared package: the default LATENCY constant, matching the adder pipeline depth.
- One natural sub-module: fadd_rsp_fifo (synchronous FWFT FIFO, DEPTH x (32+1+TAG_W), async active-low reset, full/empty/count outputs).
- Arbiter, credit counter and token pipe stay in the top module.

Test Plan:
- Single op: req0 issues a=0x3F800000, b=0x40000000, tag=3 at edge T; adder model returns 0x40400000. Required: rsp_valid at cycle T+LATENCY+1 with rsp_data=0x40400000, rsp_src=0, rsp_tag=3; busy falls after the pop.
- Contention: both requesters valid for 4 cycles from reset. Required grants in order 0,1,0,1; responses come back in that order with the correct tags.
- Backpressure: rsp_ready=0 with req0 continuously valid. Required: exactly 8 accepts, then req0_ready=0; no FIFO overflow. Then rsp_ready=1 for 1 cycle: one pop, and exactly one further accept, no earlier than the following cycle.
- Back-to-back: 20 consecutive accepts with rsp_ready=1. Required: 8 accepts, then a stall until the first result returns, then steady state with no lost or duplicated tags.
- Reset mid-flight: 5 operations in flight, rst_n low for 1 cycle. Required: all outputs read reset values immediately; no response for those operations ever appears; a new op issued after release returns normally.
- Idle: no requests for 40 cycles. Required: fa_a = fa_b = 0, rsp_valid = 0, busy = 0 throughout.
